// File: rtl/bank_readout_scheduler.sv
// Ping-pong bank scheduler: fills two sample banks alternately and walks the
// serial sender through each full bank in fill order before releasing it.
module bank_readout_scheduler #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              write_bank,
   output logic              memorization_completed,
   output logic              overrun,
   output logic              read_bank,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              tx_start,
   input  logic              tx_busy,
   input  logic              tx_done,
   output logic              sending_pending,
   output logic              sending_started,
   output logic [2:0]        state_reg_FSM
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      WAIT    = 3'd2,
      RELEASE = 3'd3
   } state_t;

   state_t     state;
   logic [1:0] full;
   logic [1:0] set_mask;
   logic [1:0] clr_mask;
   logic       fill;
   logic       release_now;

   assign wr_ready               = ~full[write_bank];
   assign wr_en                  = wr_valid & wr_ready;
   assign fill                   = wr_en & (wr_addr == LAST_ADDR);
   assign memorization_completed = fill;
   assign release_now            = (state == RELEASE);

   // Status decoded straight from registered state, no input paths.
   assign tx_start        = (state == START);
   assign sending_started = (state == START) | (state == WAIT);
   assign sending_pending = (state == IDLE) & full[read_bank];
   assign state_reg_FSM   = 3'(state);

   // Fill and release always touch different bits, so both may land together.
   always_comb begin
      set_mask = 2'b00;
      clr_mask = 2'b00;
      if (fill)        set_mask[write_bank] = 1'b1;
      if (release_now) clr_mask[read_bank]  = 1'b1;
   end

   // Write side: address counter, bank flags, bank select and overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr    <= '0;
         write_bank <= 1'b0;
         full       <= 2'b00;
         overrun    <= 1'b0;
      end else begin
         full <= (full | set_mask) & ~clr_mask;
         if (wr_en)
            wr_addr <= wr_addr + ADDR_W'(1);
         // A stalled writer re-evaluates against the registered flags each edge.
         if ((fill | full[write_bank]) & ~full[~write_bank])
            write_bank <= ~write_bank;
         if (wr_valid & ~wr_ready)
            overrun <= 1'b1;
      end
   end

   // Reader FSM: one START per word, RELEASE frees the bank and flips the select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_addr   <= '0;
         read_bank <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (full[read_bank] & ~tx_busy)
                  state <= START;
            end
            START: begin
               state <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (rd_addr == LAST_ADDR) begin
                     state <= RELEASE;
                  end else begin
                     rd_addr <= rd_addr + ADDR_W'(1);
                     state   <= START;
                  end
               end
            end
            RELEASE: begin
               read_bank <= ~read_bank;
               rd_addr   <= '0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bank_readout_scheduler.sv
// Directed bench for bank_readout_scheduler: fill, readout, stall/overrun,
// busy hold-off, stray tx_done and asynchronous reset mid-readout.
module tb_bank_readout_scheduler;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_valid = 1'b0;
   logic              tx_busy = 1'b0;
   logic              tx_done = 1'b0;
   logic              wr_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              write_bank;
   logic              memorization_completed;
   logic              overrun;
   logic              read_bank;
   logic [ADDR_W-1:0] rd_addr;
   logic              tx_start;
   logic              sending_pending;
   logic              sending_started;
   logic [2:0]        state_reg_FSM;

   int checks = 0;
   int errors = 0;

   bank_readout_scheduler #(.ADDR_W(ADDR_W)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .wr_valid               (wr_valid),
      .wr_ready               (wr_ready),
      .wr_en                  (wr_en),
      .wr_addr                (wr_addr),
      .write_bank             (write_bank),
      .memorization_completed (memorization_completed),
      .overrun                (overrun),
      .read_bank              (read_bank),
      .rd_addr                (rd_addr),
      .tx_start               (tx_start),
      .tx_busy                (tx_busy),
      .tx_done                (tx_done),
      .sending_pending        (sending_pending),
      .sending_started        (sending_started),
      .state_reg_FSM          (state_reg_FSM)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"},      32'(state_reg_FSM), 32'd0);
      check({tag, "_wr_addr"},    32'(wr_addr), 32'd0);
      check({tag, "_rd_addr"},    32'(rd_addr), 32'd0);
      check({tag, "_write_bank"}, 32'(write_bank), 32'd0);
      check({tag, "_read_bank"},  32'(read_bank), 32'd0);
      check({tag, "_overrun"},    32'(overrun), 32'd0);
      check({tag, "_wr_ready"},   32'(wr_ready), 32'd1);
      check({tag, "_tx_start"},   32'(tx_start), 32'd0);
      check({tag, "_pending"},    32'(sending_pending), 32'd0);
      check({tag, "_started"},    32'(sending_started), 32'd0);
      check({tag, "_mem_done"},   32'(memorization_completed), 32'd0);
   endtask

   task automatic do_reset;
      wr_valid = 1'b0;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      rst_n    = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   // Issue n write strobes starting at bank b0 / address a0; all must be accepted.
   task automatic fill(input int n, input int b0, input int a0);
      for (int i = 0; i < n; i++) begin
         int a;
         int b;
         a = (a0 + i) % DEPTH;
         b = (b0 + (a0 + i) / DEPTH) % 2;
         wr_valid = 1'b1;
         #1;
         check("wr_en",      32'(wr_en), 32'd1);
         check("wr_addr",    32'(wr_addr), 32'(a));
         check("write_bank", 32'(write_bank), 32'(b));
         check("mem_done",   32'(memorization_completed), (a == DEPTH - 1) ? 32'd1 : 32'd0);
         tick;
      end
      wr_valid = 1'b0;
      #1;
   endtask

   // Serve a whole bank; entered in the START cycle of word 0, tx_done 3 cycles after tx_start.
   task automatic serve_bank(input int bank);
      for (int w = 0; w < DEPTH; w++) begin
         check("tx_start",    32'(tx_start), 32'd1);
         check("rd_addr",     32'(rd_addr), 32'(w));
         check("read_bank",   32'(read_bank), 32'(bank));
         check("started",     32'(sending_started), 32'd1);
         tick;
         check("tx_start_1c", 32'(tx_start), 32'd0);
         check("state_wait",  32'(state_reg_FSM), 32'd2);
         tick;
         tick;
         tx_done = 1'b1;
         tick;
         tx_done = 1'b0;
      end
      check("state_release", 32'(state_reg_FSM), 32'd3);
      check("started_rel",   32'(sending_started), 32'd0);
      tick;
      check("state_idle",    32'(state_reg_FSM), 32'd0);
      check("read_bank_tog", 32'(read_bank), 32'(1 - bank));
      check("rd_addr_clr",   32'(rd_addr), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values while held in reset
      #1;
      check_reset_values("rst");
      tick;
      rst_n = 1'b1;
      tick;

      // Single bank fill and readout
      fill(16, 0, 0);
      check("t1_write_bank", 32'(write_bank), 32'd1);
      check("t1_pending",    32'(sending_pending), 32'd1);
      check("t1_wr_ready",   32'(wr_ready), 32'd1);
      tick;
      serve_bank(0);
      check("t2_pending", 32'(sending_pending), 32'd0);
      // Bank 1 fill must toggle back to bank 0, proving full[0] was cleared
      fill(16, 1, 0);
      check("t2_wb_back", 32'(write_bank), 32'd0);
      check("t2_pending_b1", 32'(sending_pending), 32'd1);

      // Both banks full with reader held off by tx_busy
      do_reset;
      tx_busy = 1'b1;
      fill(32, 0, 0);
      check("t3_wr_ready", 32'(wr_ready), 32'd0);
      check("t3_wb_stall", 32'(write_bank), 32'd1);
      wr_valid = 1'b1;
      #1;
      check("t3_wr_en_drop", 32'(wr_en), 32'd0);
      check("t3_mem_drop",   32'(memorization_completed), 32'd0);
      tick;
      wr_valid = 1'b0;
      check("t3_overrun", 32'(overrun), 32'd1);
      check("t3_wr_addr", 32'(wr_addr), 32'd0);
      // Stray tx_done while IDLE with a bank pending
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      tick;
      check("t5_state",   32'(state_reg_FSM), 32'd0);
      check("t5_rd_addr", 32'(rd_addr), 32'd0);
      check("t4_pending", 32'(sending_pending), 32'd1);
      tx_busy = 1'b0;
      #1;
      check("t4_no_start_yet", 32'(tx_start), 32'd0);
      tick;
      serve_bank(0);
      check("t3_wb_held",     32'(write_bank), 32'd1);
      check("t3_ready_held",  32'(wr_ready), 32'd0);
      tick;
      check("t3_wb_toggle",   32'(write_bank), 32'd0);
      check("t3_ready_back",  32'(wr_ready), 32'd1);
      check("t3_overrun_sticky", 32'(overrun), 32'd1);
      check("t3_b1_start",    32'(tx_start), 32'd1);
      check("t3_b1_rb",       32'(read_bank), 32'd1);

      // Asynchronous reset in the middle of a readout
      do_reset;
      fill(16, 0, 0);
      tick;
      for (int w = 0; w < 7; w++) begin
         tick;
         tx_done = 1'b1;
         tick;
         tx_done = 1'b0;
      end
      check("t6_rd_addr7", 32'(rd_addr), 32'd7);
      check("t6_start7",   32'(tx_start), 32'd1);
      fill(5, 1, 0);
      check("t6_partial",  32'(wr_addr), 32'd5);
      check("t6_in_wait",  32'(state_reg_FSM), 32'd2);
      rst_n = 1'b0;
      #1;
      check_reset_values("arst");
      tick;
      rst_n = 1'b1;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      check("t6_late_done_state", 32'(state_reg_FSM), 32'd0);
      check("t6_late_done_rd",    32'(rd_addr), 32'd0);
      fill(16, 0, 0);
      tick;
      serve_bank(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bank_readout_scheduler.md
# bank_readout_scheduler

Ping-pong bank scheduler for the acquisition memory. It directs acquired 7-bit samples into the current write bank and marks each bank full after DEPTH samples. It then sequences the serial sender word by word through the full bank and releases the bank for reuse. It sits between the acquisition/detection front end, the two sample banks and the serial readout transmitter, and it owns the `write_bank` and `read_bank` selects.

## Interface
Parameters:
- `ADDR_W`, 4: bank address width; DEPTH = 2^ADDR_W samples per bank.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wr_valid`  in  1  one-cycle sample strobe from acquisition.
- `wr_ready`  out  1  current write bank can accept a sample.
- `wr_en`  out  1  memory write strobe, = `wr_valid & wr_ready`.
- `wr_addr`  out  ADDR_W  write address within `write_bank`.
- `write_bank`  out  1  bank being filled.
- `memorization_completed`  out  1  one-cycle pulse on the write that fills a bank.
- `overrun`  out  1  sticky; a sample arrived while `wr_ready`=0.
- `read_bank`  out  1  bank being read out.
- `rd_addr`  out  ADDR_W  read address within `read_bank`.
- `tx_start`  out  1  one-cycle request to serialize the word at `rd_addr`.
- `tx_busy`  in  1  serializer busy.
- `tx_done`  in  1  one-cycle pulse; the current word is fully shifted out.
- `sending_pending`  out  1  a full bank is waiting and the reader is idle.
- `sending_started`  out  1  a bank readout is in progress.
- `state_reg_FSM`  out  3  reader state code for debug.

## Operation
- Flags `full[1:0]` hold one bit per bank. `wr_ready = ~full[write_bank]`.
- Write path: on `wr_en`, `wr_addr` increments. On the write at `wr_addr`=DEPTH-1:
  - `full[write_bank]` is set, `memorization_completed` pulses, and `wr_addr` wraps to 0.
  - In the same edge, `write_bank` toggles if `full[~write_bank]`=0.
  - Otherwise `write_bank` holds and the writer stalls (`wr_ready`=0). It toggles on the first edge where `full[write_bank]`=1 and `full[~write_bank]`=0.
- Overrun: `wr_valid` with `wr_ready`=0 drops the sample and sets `overrun`. Only reset clears `overrun`.
- Reader FSM (`state_reg_FSM` codes):
  - IDLE (3'd0): go to START when `full[read_bank]`=1 and `tx_busy`=0.
  - START (3'd1): `tx_start`=1 for exactly this cycle; next state WAIT.
  - WAIT (3'd2): hold until `tx_done`. If `rd_addr`=DEPTH-1, go to RELEASE; otherwise increment `rd_addr` and go to START.
  - RELEASE (3'd3): clear `full[read_bank]`, toggle `read_bank`, set `rd_addr` to 0, go to IDLE.
- `sending_pending` = (state==IDLE) & `full[read_bank]`.
- `sending_started` = state ∈ {START, WAIT}.
- `tx_done` outside WAIT is ignored.
- Bank order: banks are read in the order they were filled (0,1,0,1,…). This holds because both selects start at 0 and each toggles once per bank.
- A RELEASE that clears one flag and a fill that sets the other flag on the same edge act on different bits. Both take effect.
- A RELEASE of bank B on the same edge a stalled writer is waiting for B: the writer toggles on the following edge, because the toggle rule samples the registered `full`.

## Timing
- Reset values: `write_bank`=0, `read_bank`=0, `wr_addr`=0, `rd_addr`=0, `full`=2'b00, state=IDLE, `overrun`=0, `memorization_completed`=0, `tx_start`=0, `sending_pending`=0, `sending_started`=0, `wr_ready`=1.
- `wr_en` is combinational from `wr_valid`, with zero latency.
- `full` is set on the edge of the DEPTH-th write.
- `sending_pending` rises the cycle after the fill.
- `tx_start` is high exactly one cycle. It occurs one cycle after IDLE sees the condition, or one cycle after the `tx_done` of the previous word.
- Per-bank read overhead is 1 START cycle per word plus 1 RELEASE cycle.
- The bank is freed, `full` cleared, on the edge leaving RELEASE.
- Reset mid-operation: all state returns to reset values immediately (async). Any partial bank is discarded. A `tx_done` arriving after reset is ignored.

## Test plan
- Reset, then 16 `wr_valid` strobes:
  - `wr_addr` runs 0..15 and `memorization_completed` pulses on the 16th.
  - `write_bank`→1 on that edge; `sending_pending`=1 the next cycle.
- Bank 0 full, `tx_busy`=0, `tx_done` returned 3 cycles after each `tx_start`:
  - 16 `tx_start` pulses with `rd_addr` 0..15.
  - RELEASE follows, then `read_bank`=1 and `full[0]`=0.
- Fill banks 0 and 1 while holding `tx_done` low:
  - After 32 writes, `wr_ready`=0.
  - A 33rd `wr_valid` sets `overrun`=1 and gives no `wr_en`.
  - After bank 0 is released, `write_bank`=0 and `wr_ready`=1.
- Bank 0 full with `tx_busy`=1: FSM stays IDLE with `sending_pending`=1. Drop `tx_busy` → `tx_start` the next cycle.
- Stray `tx_done` pulses in IDLE: no change to `rd_addr` or state.
- Assert `rst_n`=0 mid-readout at `rd_addr`=7: all outputs take reset values asynchronously. After release, a fresh 16-sample fill reads out from `rd_addr`=0 in bank 0.
